// File: rtl/conv_tile_scheduler.sv
// Layer sequencer: filter-group outer loop, row-major OFM tile inner loop; optional SCHED_PERF_CNT_EN perf counters.
// Latency: start->wgt_req 1 cycle; ack->next req 1 cycle, wb_ack->next req 2 cycles (ADVANCE).
// Backpressure: each *_req is held until its ack is sampled; the sequencer never advances without an ack.
module conv_tile_scheduler #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int IFM_SIZE      = 15,
    parameter int KERNEL_SIZE   = 3,
    parameter int NO_FILTER     = 512,
    parameter int STRIDE        = 1,
    localparam int OFM_SIZE           = IFM_SIZE - KERNEL_SIZE + 1,
    localparam int NO_TILING_PER_LINE = (OFM_SIZE + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE,
    localparam int NO_TILING          = NO_TILING_PER_LINE * OFM_SIZE,
    localparam int NO_GROUP           = NO_FILTER / SYSTOLIC_SIZE,
    localparam int FW                 = $clog2(NO_GROUP + 1),
    localparam int TW                 = $clog2(NO_TILING + 1),
    localparam int RW                 = $clog2(OFM_SIZE + 1),
    localparam int CW                 = $clog2(NO_TILING_PER_LINE + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          wgt_req,
    input  logic          wgt_ack,
    output logic          ifm_req,
    input  logic          ifm_ack,
    output logic          cmp_req,
    input  logic          cmp_ack,
    output logic          wb_req,
    input  logic          wb_ack,
    output logic          wb_to_fifo,
    output logic [FW-1:0] count_filter,
    output logic [TW-1:0] count_tiling,
    output logic [RW-1:0] tile_row,
    output logic [CW-1:0] tile_col,
    output logic          busy,
    output logic          done
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]   perf_cycles,
    output logic [31:0]   perf_stall
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LD_WGT,
        LD_IFM,
        COMPUTE,
        WRITEBACK,
        ADVANCE,
        FIN
    } state_t;

    localparam logic [TW-1:0] TILE_LAST = TW'(NO_TILING - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(NO_TILING_PER_LINE - 1);
    localparam logic [FW-1:0] GRP_LAST  = FW'(NO_GROUP - 1);

    state_t state;
    logic   wb_fifo_sel;

    // Even rows are parked for pooling; with an odd OFM the trailing even row still drains via the FIFO.
    always_comb begin
        wb_fifo_sel = 1'b0;
        if (STRIDE == 2) begin
            wb_fifo_sel = ~tile_row[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wgt_req      <= 1'b0;
            ifm_req      <= 1'b0;
            cmp_req      <= 1'b0;
            wb_req       <= 1'b0;
            wb_to_fifo   <= 1'b0;
            count_filter <= '0;
            count_tiling <= '0;
            tile_row     <= '0;
            tile_col     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        count_filter <= '0;
                        count_tiling <= '0;
                        tile_row     <= '0;
                        tile_col     <= '0;
                        wgt_req      <= 1'b1;
                        state        <= LD_WGT;
                    end
                end
                LD_WGT: begin
                    if (wgt_ack) begin
                        wgt_req <= 1'b0;
                        ifm_req <= 1'b1;
                        state   <= LD_IFM;
                    end
                end
                LD_IFM: begin
                    if (ifm_ack) begin
                        ifm_req <= 1'b0;
                        cmp_req <= 1'b1;
                        state   <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (cmp_ack) begin
                        cmp_req    <= 1'b0;
                        wb_req     <= 1'b1;
                        wb_to_fifo <= wb_fifo_sel;
                        state      <= WRITEBACK;
                    end
                end
                WRITEBACK: begin
                    if (wb_ack) begin
                        wb_req     <= 1'b0;
                        wb_to_fifo <= 1'b0;
                        state      <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (count_tiling == TILE_LAST) begin
                        count_tiling <= '0;
                        tile_row     <= '0;
                        tile_col     <= '0;
                        count_filter <= count_filter + FW'(1);
                        if (count_filter == GRP_LAST) begin
                            state <= FIN;
                        end else begin
                            wgt_req <= 1'b1;
                            state   <= LD_WGT;
                        end
                    end else begin
                        count_tiling <= count_tiling + TW'(1);
                        if (tile_col == COL_LAST) begin
                            tile_col <= '0;
                            tile_row <= tile_row + RW'(1);
                        end else begin
                            tile_col <= tile_col + CW'(1);
                        end
                        ifm_req <= 1'b1;
                        state   <= LD_IFM;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic any_stall;

    always_comb begin
        any_stall = (wgt_req & ~wgt_ack) | (ifm_req & ~ifm_ack) |
                    (cmp_req & ~cmp_ack) | (wb_req & ~wb_ack);
    end

    // Both counters saturate rather than wrap so long layers never report a misleadingly small value.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (state == IDLE && start) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && perf_cycles != 32'hFFFF_FFFF) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (any_stall && perf_stall != 32'hFFFF_FFFF) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Bench for conv_tile_scheduler: two instances (STRIDE 1 and 2) share stimulus; a request-sequence model
// built from the nested layer loops is compared against both every cycle.
module tb_conv_tile_scheduler;

    localparam int SYS  = 2;
    localparam int IFM  = 5;
    localparam int KS   = 3;
    localparam int NF   = 4;
    localparam int OFM  = IFM - KS + 1;
    localparam int TPL  = (OFM + SYS - 1) / SYS;
    localparam int NT   = TPL * OFM;
    localparam int NG   = NF / SYS;
    localparam int FW   = $clog2(NG + 1);
    localparam int TW   = $clog2(NT + 1);
    localparam int RW   = $clog2(OFM + 1);
    localparam int CW   = $clog2(TPL + 1);
    localparam int NEVER = 1 << 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, wgt_ack, ifm_ack, cmp_ack, wb_ack;

    logic          a_wgt_req, a_ifm_req, a_cmp_req, a_wb_req, a_fifo, a_busy, a_done;
    logic [FW-1:0] a_count_filter;
    logic [TW-1:0] a_count_tiling;
    logic [RW-1:0] a_tile_row;
    logic [CW-1:0] a_tile_col;
    logic          b_wgt_req, b_ifm_req, b_cmp_req, b_wb_req, b_fifo, b_busy, b_done;
    logic [FW-1:0] b_count_filter;
    logic [TW-1:0] b_count_tiling;
    logic [RW-1:0] b_tile_row;
    logic [CW-1:0] b_tile_col;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]   a_perf_cycles, a_perf_stall, b_perf_cycles, b_perf_stall;
`endif

    conv_tile_scheduler #(.SYSTOLIC_SIZE(SYS), .IFM_SIZE(IFM), .KERNEL_SIZE(KS), .NO_FILTER(NF), .STRIDE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start),
        .wgt_req(a_wgt_req), .wgt_ack(wgt_ack), .ifm_req(a_ifm_req), .ifm_ack(ifm_ack),
        .cmp_req(a_cmp_req), .cmp_ack(cmp_ack), .wb_req(a_wb_req), .wb_ack(wb_ack),
        .wb_to_fifo(a_fifo), .count_filter(a_count_filter), .count_tiling(a_count_tiling),
        .tile_row(a_tile_row), .tile_col(a_tile_col), .busy(a_busy), .done(a_done)
`ifdef SCHED_PERF_CNT_EN
        , .perf_cycles(a_perf_cycles), .perf_stall(a_perf_stall)
`endif
    );

    conv_tile_scheduler #(.SYSTOLIC_SIZE(SYS), .IFM_SIZE(IFM), .KERNEL_SIZE(KS), .NO_FILTER(NF), .STRIDE(2)) dut_b (
        .clk(clk), .rst(rst), .start(start),
        .wgt_req(b_wgt_req), .wgt_ack(wgt_ack), .ifm_req(b_ifm_req), .ifm_ack(ifm_ack),
        .cmp_req(b_cmp_req), .cmp_ack(cmp_ack), .wb_req(b_wb_req), .wb_ack(wb_ack),
        .wb_to_fifo(b_fifo), .count_filter(b_count_filter), .count_tiling(b_count_tiling),
        .tile_row(b_tile_row), .tile_col(b_tile_col), .busy(b_busy), .done(b_done)
`ifdef SCHED_PERF_CNT_EN
        , .perf_cycles(b_perf_cycles), .perf_stall(b_perf_stall)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Model: one entry per request the layer must issue, in order (kind 0=wgt 1=ifm 2=cmp 3=wb).
    typedef struct {
        int kind;
        int grp;
        int tile;
        int row;
        int col;
        int fifo2;
    } ev_t;

    ev_t q[$];

    task automatic build_model();
        ev_t e;
        int  t;
        q.delete();
        for (int g = 0; g < NG; g++) begin
            e = '{kind: 0, grp: g, tile: 0, row: 0, col: 0, fifo2: 0};
            q.push_back(e);
            t = 0;
            for (int r = 0; r < OFM; r++) begin
                for (int c = 0; c < TPL; c++) begin
                    for (int k = 1; k <= 3; k++) begin
                        e = '{kind: k, grp: g, tile: t, row: r, col: c, fifo2: (r % 2 == 0) ? 1 : 0};
                        q.push_back(e);
                    end
                    t++;
                end
            end
        end
    endtask

    // Bench-side state shared between the cycle checker and the directed sequence.
    logic       check_en = 1'b0;
    logic       tie = 1'b0;
    int         delay = 1;
    int         cyc = 0;
    logic       pending = 1'b0;
    logic       holding = 1'b0;
    int         hold_kind = 0;
    int         exp_rise = 0;
    int         busy_from = -1;
    int         busy_until = NEVER;
    int         done_from = -1;
    int         n_rise [4];
    int         busy_cnt = 0;
    int         hold_cnt [4];
    logic [3:0] act_a, act_b, prev_a, exp_v, ackv;
    logic       exp_busy, exp_done;
    int         fifo_log [6];
    ev_t        ev;

    initial begin
        wgt_ack = 1'b0; ifm_ack = 1'b0; cmp_ack = 1'b0; wb_ack = 1'b0;
        prev_a = '0;
        for (int k = 0; k < 4; k++) begin
            n_rise[k] = 0;
            hold_cnt[k] = 0;
        end
        for (int i = 0; i < 6; i++) fifo_log[i] = -1;
        forever begin
            @(negedge clk);
            cyc++;
            act_a = {a_wb_req, a_cmp_req, a_ifm_req, a_wgt_req};
            act_b = {b_wb_req, b_cmp_req, b_ifm_req, b_wgt_req};
            exp_busy = (busy_from >= 0) && (cyc >= busy_from) && (cyc < busy_until);
            exp_done = (done_from >= 0) && (cyc >= done_from);
            if (check_en) begin
                exp_v = '0;
                if (pending && cyc == exp_rise) begin
                    ev = q.pop_front();
                    exp_v[ev.kind] = 1'b1;
                    pending = 1'b0;
                    holding = 1'b1;
                    hold_kind = ev.kind;
                    chk("rise_count_filter", 32'(a_count_filter), ev.grp);
                    chk("rise_count_tiling", 32'(a_count_tiling), ev.tile);
                    chk("rise_tile_row", 32'(a_tile_row), ev.row);
                    chk("rise_tile_col", 32'(a_tile_col), ev.col);
                    chk("rise_b_count_tiling", 32'(b_count_tiling), ev.tile);
                    if (ev.kind == 3) begin
                        chk("wb_to_fifo_stride1", 32'(a_fifo), 0);
                        chk("wb_to_fifo_stride2", 32'(b_fifo), ev.fifo2);
                    end
                end else if (holding) begin
                    exp_v[hold_kind] = 1'b1;
                end
                chk("reqs_a", 32'(act_a), 32'(exp_v));
                chk("reqs_b", 32'(act_b), 32'(exp_v));
                chk("busy_a", 32'(a_busy), 32'(exp_busy));
                chk("done_a", 32'(a_done), 32'(exp_done));
                chk("busy_b", 32'(b_busy), 32'(exp_busy));
                chk("done_b", 32'(b_done), 32'(exp_done));
                if (exp_done) chk("final_count_filter", 32'(a_count_filter), NG);
            end
            // Statistics taken from the DUT's actual request edges.
            for (int k = 0; k < 4; k++) begin
                if (act_a[k] && !prev_a[k]) begin
                    n_rise[k]++;
                    if (k == 3 && a_count_filter == 0 && n_rise[3] <= 6) fifo_log[n_rise[3] - 1] = int'(b_fifo);
                end
            end
            if (a_busy === 1'b1) busy_cnt++;
            prev_a = act_a;
            // Responder: ack after the request has been seen for delay+1 cycles, or tied high.
            for (int k = 0; k < 4; k++) begin
                hold_cnt[k] = act_a[k] ? hold_cnt[k] + 1 : 0;
                ackv[k] = tie ? 1'b1 : (act_a[k] && hold_cnt[k] == delay + 1);
            end
            wgt_ack = ackv[0]; ifm_ack = ackv[1]; cmp_ack = ackv[2]; wb_ack = ackv[3];
            if (holding && ackv[hold_kind]) begin
                holding = 1'b0;
                if (q.size() > 0) begin
                    pending = 1'b1;
                    exp_rise = cyc + ((hold_kind == 3) ? 2 : 1);
                end else begin
                    busy_until = cyc + 3;
                    done_from = cyc + 3;
                end
            end
            if (start && !rst && !exp_busy) begin
                build_model();
                pending = 1'b1;
                holding = 1'b0;
                exp_rise = cyc + 1;
                busy_from = cyc + 1;
                busy_until = NEVER;
                done_from = -1;
                busy_cnt = 0;
                for (int k = 0; k < 4; k++) n_rise[k] = 0;
            end
            if (rst) begin
                q.delete();
                pending = 1'b0;
                holding = 1'b0;
                busy_from = -1;
                done_from = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (a_done === 1'b1) break;
        end
        chk("done_reached", 32'(a_done), 1);
    endtask

    task automatic chk_counts(input string tag, input int busy_exp);
        chk({tag, "_wgt_reqs"}, n_rise[0], 2);
        chk({tag, "_ifm_reqs"}, n_rise[1], 12);
        chk({tag, "_cmp_reqs"}, n_rise[2], 12);
        chk({tag, "_wb_reqs"}, n_rise[3], 12);
        chk({tag, "_busy_cycles"}, busy_cnt, busy_exp);
        chk({tag, "_count_filter"}, 32'(a_count_filter), 2);
        chk({tag, "_busy_after"}, 32'(a_busy), 0);
    endtask

    initial begin
        logic found;
        int   fifo_exp [6];
        fifo_exp = '{1, 1, 0, 0, 1, 1};
        rst = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        chk("rst_reqs", 32'({a_wb_req, a_cmp_req, a_ifm_req, a_wgt_req}), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_count_filter", 32'(a_count_filter), 0);
        chk("rst_count_tiling", 32'(a_count_tiling), 0);
        chk("rst_tile_row", 32'(a_tile_row), 0);
        chk("rst_tile_col", 32'(a_tile_col), 0);
        chk("rst_fifo_b", 32'(b_fifo), 0);
        rst = 1'b0;
        check_en = 1'b1;
        tick();

        // Acks tied high: every request is a one-cycle pulse, 2*(1+6*4)+1 busy cycles.
        tie = 1'b1;
        pulse_start();
        wait_done();
        chk_counts("tied", 51);
        for (int i = 0; i < 6; i++) chk("stride2_fifo_pattern", fifo_log[i], fifo_exp[i]);

        // Acks one cycle after each request: 2 cycles per req, 7 per tile, 2*(2+42)+1 busy.
        tie = 1'b0;
        delay = 1;
        tick();
        pulse_start();
        wait_done();
        chk_counts("delay1", 89);

        // Acks three cycles late; a start during COMPUTE of tile 2 must change nothing.
        delay = 3;
        tick();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (a_cmp_req === 1'b1 && a_count_tiling == 2) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_compute_tile2", 32'(found), 1);
        pulse_start();
        chk("ign_start_cmp_req", 32'(a_cmp_req), 1);
        chk("ign_start_count_tiling", 32'(a_count_tiling), 2);
        chk("ign_start_tile_row", 32'(a_tile_row), 1);
        chk("ign_start_tile_col", 32'(a_tile_col), 0);
        chk("ign_start_count_filter", 32'(a_count_filter), 0);
        wait_done();
        chk_counts("delay3", 165);
`ifdef SCHED_PERF_CNT_EN
        chk("perf_stall", a_perf_stall, 114);
        chk("perf_cycles", a_perf_cycles, 165);
        chk("perf_stall_b", b_perf_stall, 114);
`endif

        // Reset in the middle of tile 3's writeback, then a clean restart.
        delay = 1;
        tick();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (a_wb_req === 1'b1 && a_count_tiling == 3) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_wb_tile3", 32'(found), 1);
        rst = 1'b1;
        tick();
        chk("midrst_reqs", 32'({a_wb_req, a_cmp_req, a_ifm_req, a_wgt_req}), 0);
        chk("midrst_busy", 32'(a_busy), 0);
        chk("midrst_done", 32'(a_done), 0);
        chk("midrst_count_tiling", 32'(a_count_tiling), 0);
        rst = 1'b0;
        tick();
        pulse_start();
        chk("restart_wgt_req", 32'(a_wgt_req), 1);
        chk("restart_count_filter", 32'(a_count_filter), 0);
        chk("restart_count_tiling", 32'(a_count_tiling), 0);
        wait_done();
        chk_counts("restart", 89);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
